hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Central pipeline control block that generates the Ld/Clr strobes consumed by the PC and by the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers.
- Detects three conditions:
  - load-use hazards
  - taken branch/jump redirects resolved in MEM
  - multi-cycle mult/div occupancy of HI/LO
- From these it decides, per cycle, which stages hold, which advance and which are squashed.
- It drives the Clr/Ld inputs of every pipeline register.

Parameters:
- MULT_CYCLES, 4, total busy cycles for mult/multu (HI/LO valid after this many cycles)
- DIV_CYCLES, 8, total busy cycles for div/divu
- CNT_W, 4, busy-counter width; must hold max(MULT_CYCLES, DIV_CYCLES)-1

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  synchronous, active-high reset
- ID_Rs  in  5  rs field of instruction in ID
- ID_Rt  in  5  rt field of instruction in ID
- ID_UsesRt  in  1  ID instruction reads rt as a source
- ID_UsesHiLo  in  1  ID instruction is mfhi/mflo/mthi/mtlo or mult/div
- EX_MemRead  in  1  instruction in EX is a load
- EX_RegDstData  in  5  destination register of instruction in EX
- EX_MulDivStart  in  1  instruction in EX is mult/multu/div/divu
- EX_IsDiv  in  1  qualifies EX_MulDivStart: 1=div, 0=mult
- MEM_Branch  in  1  branch in MEM
- MEM_Zero  in  1  branch condition true
- MEM_Jump  in  2  jump type in MEM; nonzero = jump taken
- PC_Ld  out  1  PC load enable
- PCSrc_Redirect  out  1  PC mux selects MEM target
- IF_ID_Ld, IF_ID_Clr  out  1 each
- ID_EX_Ld, ID_EX_Clr  out  1 each
- EX_MEM_Ld, EX_MEM_Clr  out  1 each
- MEM_WB_Ld, MEM_WB_Clr  out  1 each
- MulDivBusy  out  1  HI/LO unit occupied
- MulDivDone  out  1  one-cycle pulse on final busy cycle

Behaviour:
- Clocking and reset:
  - Single clock domain Clk.
  - Reset is synchronous and active-high.
  - State and counter are registered; strobe outputs are combinational from state and inputs.
- During Reset = 1:
  - All *_Clr = 1, all *_Ld = 0, PC_Ld = 0.
  - PCSrc_Redirect = 0, MulDivBusy = 0, MulDivDone = 0.
  - Next state IDLE, cnt = 0.
- Definitions:
  - Redirect = (MEM_Branch & MEM_Zero) | (MEM_Jump != 0).
  - LoadUse = EX_MemRead & (EX_RegDstData != 0) & ((EX_RegDstData == ID_Rs) | (ID_UsesRt & EX_RegDstData == ID_Rt)).
  - MdHaz = MulDivBusy & ID_UsesHiLo.
- FSM states:
  - IDLE: MulDivBusy = 0.
  - BUSY: MulDivBusy = 1.
- Default, no event: all Ld = 1, all Clr = 0, PC_Ld = 1, PCSrc_Redirect = 0.
- Priority, highest first:
  1. Redirect:
     - PC_Ld = 1, PCSrc_Redirect = 1.
     - IF_ID_Clr = ID_EX_Clr = EX_MEM_Clr = 1.
     - MEM_WB_Ld = 1.
     - LoadUse and MdHaz are ignored, since the affected instructions are squashed.
  2. Stall, when MdHaz or LoadUse:
     - PC_Ld = 0, IF_ID_Ld = 0 (hold).
     - ID_EX_Clr = 1 (bubble).
     - EX_MEM_Ld = MEM_WB_Ld = 1.
  3. Normal advance.
- Load-use stall lasts exactly 1 cycle; the next cycle the load is in MEM and LoadUse is false.
- Mult/div start:
  - In IDLE, EX_MulDivStart & !Redirect: next state BUSY.
  - cnt <= (EX_IsDiv ? DIV_CYCLES : MULT_CYCLES) - 1.
  - The start condition itself does not stall.
  - EX_MulDivStart coincident with Redirect is ignored: the younger instruction is flushed and the state stays IDLE.
- BUSY behaviour:
  - cnt decrements every cycle, independent of stalls and redirects; the op is older and committed.
  - When cnt == 0 in BUSY: MulDivDone = 1 that cycle, next state IDLE.
  - MdHaz stalls until the cycle after MulDivDone, so an mfhi sees results the cycle it leaves ID.
  - EX_MulDivStart while BUSY is ignored; MdHaz prevents this in legal flow.
- Reset mid-BUSY: abort immediately, IDLE next cycle, no MulDivDone.
- MULT_CYCLES = 1 is legal: BUSY for one cycle with MulDivDone = 1.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state encoding (IDLE = 1'b0, BUSY = 1'b1)
  - MULT_CYCLES/DIV_CYCLES defaults
  - JUMP_NONE = 2'b00
- Sub-module muldiv_busy_cnt (loadable down-counter plus FSM, outputs MulDivBusy/MulDivDone); hazard and priority logic stays in the top.

Test Plan:
- Reset held 3 cycles -> all Clr = 1, all Ld = 0, MulDivBusy = 0. After release with no events -> all Ld = 1, all Clr = 0.
- lw writing $8 in EX (EX_MemRead = 1, EX_RegDstData = 8), ID_Rs = 8 -> exactly one cycle with PC_Ld = 0, IF_ID_Ld = 0, ID_EX_Clr = 1, then normal. Same with EX_RegDstData = 0 -> no stall.
- MEM_Branch = 1, MEM_Zero = 1 while LoadUse is also true -> PCSrc_Redirect = 1, IF_ID_Clr/ID_EX_Clr/EX_MEM_Clr = 1, PC_Ld = 1, no stall.
- EX_MulDivStart = 1, EX_IsDiv = 1, then ID_UsesHiLo = 1 held -> MulDivBusy for 8 cycles, MulDivDone on the 8th, stall for those 8 cycles, advance on the 9th.
- EX_MulDivStart = 1 with MEM_Jump = 2'b10 the same cycle -> redirect flush, MulDivBusy stays 0.
- Reset asserted on busy cycle 3 of a mult -> IDLE next cycle, MulDivDone never pulses.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller:
// mult/div FSM encoding, default latencies and jump encoding.
package pipe_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    localparam int MULT_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF  = 8;

    localparam logic [1:0] JUMP_NONE = 2'b00;

    // One record for every Ld/Clr strobe so priority cases assign them as a group.
    typedef struct packed {
        logic pc_ld;
        logic pc_src_redirect;
        logic if_id_ld;
        logic if_id_clr;
        logic id_ex_ld;
        logic id_ex_clr;
        logic ex_mem_ld;
        logic ex_mem_clr;
        logic mem_wb_ld;
        logic mem_wb_clr;
    } strobes_t;

    localparam strobes_t STROBES_RESET = '{
        pc_ld: 1'b0, pc_src_redirect: 1'b0,
        if_id_ld: 1'b0, if_id_clr: 1'b1,
        id_ex_ld: 1'b0, id_ex_clr: 1'b1,
        ex_mem_ld: 1'b0, ex_mem_clr: 1'b1,
        mem_wb_ld: 1'b0, mem_wb_clr: 1'b1
    };

    localparam strobes_t STROBES_ADVANCE = '{
        pc_ld: 1'b1, pc_src_redirect: 1'b0,
        if_id_ld: 1'b1, if_id_clr: 1'b0,
        id_ex_ld: 1'b1, id_ex_clr: 1'b0,
        ex_mem_ld: 1'b1, ex_mem_clr: 1'b0,
        mem_wb_ld: 1'b1, mem_wb_clr: 1'b0
    };

endpackage

// File: rtl/muldiv_busy_cnt.sv
// HI/LO occupancy tracker: loadable down-counter plus IDLE/BUSY FSM.
// Done pulses on the final busy cycle; reset aborts without a Done.
module muldiv_busy_cnt
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Start,
    input  logic IsDiv,
    output logic Busy,
    output logic Done
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        Busy      = 1'b0;
        Done      = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_nxt = BUSY;
                    cnt_nxt   = IsDiv ? DIV_LOAD : MULT_LOAD;
                end
            end
            BUSY: begin
                Busy = 1'b1;
                if (cnt == '0) begin
                    Done      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Outputs are quiet while Reset is held even if the register still says BUSY.
        if (Reset) begin
            Busy = 1'b0;
            Done = 1'b0;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline control: detects redirects, load-use and HI/LO hazards and
// drives the PC and pipeline-register Ld/Clr strobes by priority.
module hazard_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [4:0] ID_Rs,
    input  logic [4:0] ID_Rt,
    input  logic       ID_UsesRt,
    input  logic       ID_UsesHiLo,
    input  logic       EX_MemRead,
    input  logic [4:0] EX_RegDstData,
    input  logic       EX_MulDivStart,
    input  logic       EX_IsDiv,
    input  logic       MEM_Branch,
    input  logic       MEM_Zero,
    input  logic [1:0] MEM_Jump,
    output logic       PC_Ld,
    output logic       PCSrc_Redirect,
    output logic       IF_ID_Ld,
    output logic       IF_ID_Clr,
    output logic       ID_EX_Ld,
    output logic       ID_EX_Clr,
    output logic       EX_MEM_Ld,
    output logic       EX_MEM_Clr,
    output logic       MEM_WB_Ld,
    output logic       MEM_WB_Clr,
    output logic       MulDivBusy,
    output logic       MulDivDone
);

    logic     redirect;
    logic     load_use;
    logic     md_haz;
    logic     md_start;
    strobes_t strb;

    assign redirect = (MEM_Branch & MEM_Zero) | (MEM_Jump != JUMP_NONE);

    assign load_use = EX_MemRead & (EX_RegDstData != 5'd0) &
                      ((EX_RegDstData == ID_Rs) | (ID_UsesRt & (EX_RegDstData == ID_Rt)));

    assign md_haz = MulDivBusy & ID_UsesHiLo;

    // A mult/div sharing its cycle with a redirect is a younger, squashed instruction.
    assign md_start = EX_MulDivStart & ~redirect;

    muldiv_busy_cnt #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_muldiv_busy_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (md_start),
        .IsDiv (EX_IsDiv),
        .Busy  (MulDivBusy),
        .Done  (MulDivDone)
    );

    always_comb begin
        strb = STROBES_ADVANCE;
        if (Reset) begin
            strb = STROBES_RESET;
        end else if (redirect) begin
            strb.pc_src_redirect = 1'b1;
            strb.if_id_clr       = 1'b1;
            strb.id_ex_clr       = 1'b1;
            strb.ex_mem_clr      = 1'b1;
        end else if (md_haz | load_use) begin
            // Hold PC and IF/ID, inject a bubble into ID/EX, let older stages drain.
            strb.pc_ld     = 1'b0;
            strb.if_id_ld  = 1'b0;
            strb.id_ex_clr = 1'b1;
        end
    end

    assign PC_Ld          = strb.pc_ld;
    assign PCSrc_Redirect = strb.pc_src_redirect;
    assign IF_ID_Ld       = strb.if_id_ld;
    assign IF_ID_Clr      = strb.if_id_clr;
    assign ID_EX_Ld       = strb.id_ex_ld;
    assign ID_EX_Clr      = strb.id_ex_clr;
    assign EX_MEM_Ld      = strb.ex_mem_ld;
    assign EX_MEM_Clr     = strb.ex_mem_clr;
    assign MEM_WB_Ld      = strb.mem_wb_ld;
    assign MEM_WB_Clr     = strb.mem_wb_clr;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl with hand-computed strobe patterns.
module tb_hazard_stall_ctrl;

    logic       Clk;
    logic       Reset;
    logic [4:0] ID_Rs, ID_Rt;
    logic       ID_UsesRt, ID_UsesHiLo;
    logic       EX_MemRead;
    logic [4:0] EX_RegDstData;
    logic       EX_MulDivStart, EX_IsDiv;
    logic       MEM_Branch, MEM_Zero;
    logic [1:0] MEM_Jump;
    logic       PC_Ld, PCSrc_Redirect;
    logic       IF_ID_Ld, IF_ID_Clr, ID_EX_Ld, ID_EX_Clr;
    logic       EX_MEM_Ld, EX_MEM_Clr, MEM_WB_Ld, MEM_WB_Clr;
    logic       MulDivBusy, MulDivDone;

    int checks = 0;
    int passed = 0;

    // Order: PC_Ld PCSrc IF_ID{Ld,Clr} ID_EX{Ld,Clr} EX_MEM{Ld,Clr} MEM_WB{Ld,Clr} Busy Done
    logic [11:0] outs;
    assign outs = {PC_Ld, PCSrc_Redirect, IF_ID_Ld, IF_ID_Clr, ID_EX_Ld, ID_EX_Clr,
                   EX_MEM_Ld, EX_MEM_Clr, MEM_WB_Ld, MEM_WB_Clr, MulDivBusy, MulDivDone};

    localparam logic [9:0] S_RESET  = 10'b00_01_01_01_01;
    localparam logic [9:0] S_NORMAL = 10'b10_10_10_10_10;
    localparam logic [9:0] S_STALL  = 10'b00_00_11_10_10;
    localparam logic [9:0] S_REDIR  = 10'b11_11_11_11_10;

    hazard_stall_ctrl #(
        .MULT_CYCLES (4),
        .DIV_CYCLES  (8),
        .CNT_W       (4)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .ID_Rs          (ID_Rs),
        .ID_Rt          (ID_Rt),
        .ID_UsesRt      (ID_UsesRt),
        .ID_UsesHiLo    (ID_UsesHiLo),
        .EX_MemRead     (EX_MemRead),
        .EX_RegDstData  (EX_RegDstData),
        .EX_MulDivStart (EX_MulDivStart),
        .EX_IsDiv       (EX_IsDiv),
        .MEM_Branch     (MEM_Branch),
        .MEM_Zero       (MEM_Zero),
        .MEM_Jump       (MEM_Jump),
        .PC_Ld          (PC_Ld),
        .PCSrc_Redirect (PCSrc_Redirect),
        .IF_ID_Ld       (IF_ID_Ld),
        .IF_ID_Clr      (IF_ID_Clr),
        .ID_EX_Ld       (ID_EX_Ld),
        .ID_EX_Clr      (ID_EX_Clr),
        .EX_MEM_Ld      (EX_MEM_Ld),
        .EX_MEM_Clr     (EX_MEM_Clr),
        .MEM_WB_Ld      (MEM_WB_Ld),
        .MEM_WB_Clr     (MEM_WB_Clr),
        .MulDivBusy     (MulDivBusy),
        .MulDivDone     (MulDivDone)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic idle_inputs();
        ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b0; ID_UsesHiLo = 1'b0;
        EX_MemRead = 1'b0; EX_RegDstData = 5'd0;
        EX_MulDivStart = 1'b0; EX_IsDiv = 1'b0;
        MEM_Branch = 1'b0; MEM_Zero = 1'b0; MEM_Jump = 2'b00;
    endtask

    task automatic next_cycle();
        @(negedge Clk);
        idle_inputs();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk); #1;
            checks++;
            if (outs !== {S_RESET, 2'b00})
                $display("FAIL reset_cyc%0d got=%b exp=%b", i, outs, {S_RESET, 2'b00});
            else passed++;
        end
        @(negedge Clk);
        Reset = 1'b0; #1;
        checks++;
        if (outs !== {S_NORMAL, 2'b00})
            $display("FAIL reset_release got=%b exp=%b", outs, {S_NORMAL, 2'b00});
        else passed++;
    endtask

    task automatic test_load_use();
        next_cycle();
        EX_MemRead = 1'b1; EX_RegDstData = 5'd8; ID_Rs = 5'd8; #1;
        checks++;
        if (outs !== {S_STALL, 2'b00}) $display("FAIL lu_rs got=%b exp=%b", outs, {S_STALL, 2'b00});
        else passed++;
        // Load has moved to MEM: same ID instruction now advances.
        next_cycle();
        ID_Rs = 5'd8; #1;
        checks++;
        if (outs !== {S_NORMAL, 2'b00}) $display("FAIL lu_after got=%b exp=%b", outs, {S_NORMAL, 2'b00});
        else passed++;
        next_cycle();
        EX_MemRead = 1'b1; EX_RegDstData = 5'd8; ID_Rs = 5'd3; ID_Rt = 5'd8; ID_UsesRt = 1'b1; #1;
        checks++;
        if (outs !== {S_STALL, 2'b00}) $display("FAIL lu_rt got=%b exp=%b", outs, {S_STALL, 2'b00});
        else passed++;
        next_cycle();
        EX_MemRead = 1'b1; EX_RegDstData = 5'd8; ID_Rs = 5'd3; ID_Rt = 5'd8; ID_UsesRt = 1'b0; #1;
        checks++;
        if (outs !== {S_NORMAL, 2'b00}) $display("FAIL lu_rt_unused got=%b exp=%b", outs, {S_NORMAL, 2'b00});
        else passed++;
        next_cycle();
        EX_MemRead = 1'b1; EX_RegDstData = 5'd0; ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b1; #1;
        checks++;
        if (outs !== {S_NORMAL, 2'b00}) $display("FAIL lu_r0 got=%b exp=%b", outs, {S_NORMAL, 2'b00});
        else passed++;
    endtask

    task automatic test_redirect();
        next_cycle();
        MEM_Branch = 1'b1; MEM_Zero = 1'b1;
        EX_MemRead = 1'b1; EX_RegDstData = 5'd8; ID_Rs = 5'd8; #1;
        checks++;
        if (outs !== {S_REDIR, 2'b00}) $display("FAIL br_over_lu got=%b exp=%b", outs, {S_REDIR, 2'b00});
        else passed++;
        next_cycle();
        MEM_Branch = 1'b1; MEM_Zero = 1'b0; #1;
        checks++;
        if (outs !== {S_NORMAL, 2'b00}) $display("FAIL br_not_taken got=%b exp=%b", outs, {S_NORMAL, 2'b00});
        else passed++;
        next_cycle();
        MEM_Jump = 2'b01; #1;
        checks++;
        if (outs !== {S_REDIR, 2'b00}) $display("FAIL jump got=%b exp=%b", outs, {S_REDIR, 2'b00});
        else passed++;
    endtask

    task automatic test_div_hazard();
        logic [11:0] exp;
        next_cycle();
        EX_MulDivStart = 1'b1; EX_IsDiv = 1'b1; #1;
        checks++;
        if (outs !== {S_NORMAL, 2'b00}) $display("FAIL div_start got=%b exp=%b", outs, {S_NORMAL, 2'b00});
        else passed++;
        for (int i = 1; i <= 8; i++) begin
            next_cycle();
            ID_UsesHiLo = 1'b1; #1;
            exp = {S_STALL, 1'b1, (i == 8)};
            checks++;
            if (outs !== exp) $display("FAIL div_busy%0d got=%b exp=%b", i, outs, exp);
            else passed++;
        end
        next_cycle();
        ID_UsesHiLo = 1'b1; #1;
        checks++;
        if (outs !== {S_NORMAL, 2'b00}) $display("FAIL div_release got=%b exp=%b", outs, {S_NORMAL, 2'b00});
        else passed++;
    endtask

    task automatic test_mult_no_hazard();
        logic [11:0] exp;
        next_cycle();
        EX_MulDivStart = 1'b1; EX_IsDiv = 1'b0; #1;
        for (int i = 1; i <= 4; i++) begin
            next_cycle(); #1;
            exp = {S_NORMAL, 1'b1, (i == 4)};
            checks++;
            if (outs !== exp) $display("FAIL mult_busy%0d got=%b exp=%b", i, outs, exp);
            else passed++;
        end
        next_cycle(); #1;
        checks++;
        if (outs !== {S_NORMAL, 2'b00}) $display("FAIL mult_idle got=%b exp=%b", outs, {S_NORMAL, 2'b00});
        else passed++;
    endtask

    task automatic test_start_with_jump();
        next_cycle();
        EX_MulDivStart = 1'b1; EX_IsDiv = 1'b1; MEM_Jump = 2'b10; #1;
        checks++;
        if (outs !== {S_REDIR, 2'b00}) $display("FAIL start_jump got=%b exp=%b", outs, {S_REDIR, 2'b00});
        else passed++;
        next_cycle();
        ID_UsesHiLo = 1'b1; #1;
        checks++;
        if (outs !== {S_NORMAL, 2'b00}) $display("FAIL start_jump_idle got=%b exp=%b", outs, {S_NORMAL, 2'b00});
        else passed++;
    endtask

    task automatic test_reset_mid_mult();
        int done_seen;
        done_seen = 0;
        next_cycle();
        EX_MulDivStart = 1'b1; EX_IsDiv = 1'b0; #1;
        for (int i = 1; i <= 2; i++) begin
            next_cycle(); #1;
            checks++;
            if (outs !== {S_NORMAL, 2'b10}) $display("FAIL abort_busy%0d got=%b exp=%b", i, outs, {S_NORMAL, 2'b10});
            else passed++;
        end
        next_cycle();
        Reset = 1'b1; #1;
        checks++;
        if (outs !== {S_RESET, 2'b00}) $display("FAIL abort_reset got=%b exp=%b", outs, {S_RESET, 2'b00});
        else passed++;
        next_cycle();
        Reset = 1'b0; #1;
        checks++;
        if (outs !== {S_NORMAL, 2'b00}) $display("FAIL abort_idle got=%b exp=%b", outs, {S_NORMAL, 2'b00});
        else passed++;
        for (int i = 0; i < 4; i++) begin
            next_cycle(); #1;
            if (MulDivDone !== 1'b0 || MulDivBusy !== 1'b0) done_seen++;
        end
        checks++;
        if (done_seen != 0) $display("FAIL abort_no_done got=%0d exp=0", done_seen);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_redirect();
        test_div_hazard();
        test_mult_no_hazard();
        test_start_with_jump();
        test_reset_mid_mult();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
